// File: rtl/jstk_pkg.sv
// Shared types and constants for the PmodJSTK SPI slave emulator.
// Byte indices name the position of each field in the 5-byte joystick frame.
package jstk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int FRAME_BYTES = 5;
  localparam logic [5:0] CMD_PREFIX = 6'b100000;

  localparam int B0_IDX = 0;
  localparam int B1_IDX = 1;
  localparam int B2_IDX = 2;
  localparam int B3_IDX = 3;
  localparam int B4_IDX = 4;

  // Frame byte for a given index; indices past the last field read as zero.
  function automatic logic [7:0] tx_byte(input int idx, input logic [9:0] x,
                                         input logic [9:0] y, input logic [2:0] btn);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      B0_IDX:  b = x[7:0];
      B1_IDX:  b = {6'b0, x[9:8]};
      B2_IDX:  b = y[7:0];
      B3_IDX:  b = {6'b0, y[9:8]};
      B4_IDX:  b = {5'b0, btn};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jstk_spi_slave_sync_edge.sv
// Multi-flop synchronizer with one-cycle rise/fall pulses on the synchronized level.
// Reset value sets the idle level so leaving reset produces no false edge.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign rise = r_sync[STAGES-1] & ~r_prev;
  assign fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/jstk_spi_slave.sv
// PmodJSTK emulator: SPI mode-0 slave returning joystick position/buttons
// and taking an LED command from the first received byte of each frame.
//
// state    | meaning
// ST_IDLE  | waiting for ss to fall; miso held low
// ST_SHIFT | frame in progress; shifting rx on sclk rise, tx on sclk fall
// ST_HOLD  | all frame bits received; sclk ignored until ss rises
module jstk_spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = jstk_pkg::FRAME_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sclk,
  input  logic       mosi,
  output logic       miso,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [2:0] buttons,
  output logic [1:0] led,
  output logic       xfer_done,
  output logic       frame_err
);
  import jstk_pkg::*;

  localparam int BCW = $clog2(FRAME_BYTES + 1);
  localparam int SCW = $clog2(SYNC_STAGES + 2);

  state_t r_state, w_state_nxt;

  logic                   w_ss_rise, w_ss_fall, w_sclk_rise, w_sclk_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi_s;
  logic [SCW-1:0]         r_settle;
  logic                   w_start, w_last_bit, w_miso;
  logic [2:0]             r_bit_cnt;
  logic [BCW-1:0]         r_byte_cnt;
  logic [7:0]             r_tx, r_rx, r_cmd;
  logic [9:0]             r_snap_x, r_snap_y;
  logic [2:0]             r_snap_btn;
  logic [1:0]             r_led;
  logic                   r_xfer_done, r_frame_err;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(ss), .rise(w_ss_rise), .fall(w_ss_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .rise(w_sclk_rise), .fall(w_sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) r_mosi_sync <= '0;
    else     r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

  // A fall seen while the ss chain is still flushing its reset value is an
  // artefact of reset released mid-frame, not a new frame start.
  assign w_start    = (r_state == ST_IDLE) && w_ss_fall && (r_settle == '0);
  assign w_last_bit = (r_bit_cnt == 3'd7) && (r_byte_cnt == BCW'(FRAME_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (w_ss_rise)                      w_state_nxt = ST_IDLE;
        else if (w_sclk_rise && w_last_bit) w_state_nxt = ST_HOLD;
      end
      ST_HOLD:  if (w_ss_rise) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_miso = 1'b0;
    if (r_state == ST_SHIFT) w_miso = r_tx[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_settle    <= SCW'(SYNC_STAGES + 1);
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_cmd       <= '0;
      r_snap_x    <= '0;
      r_snap_y    <= '0;
      r_snap_btn  <= '0;
      r_led       <= 2'b00;
      r_xfer_done <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_xfer_done <= 1'b0;
      r_frame_err <= 1'b0;
      if (r_settle != '0) r_settle <= r_settle - SCW'(1);
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_snap_x   <= pos_x;
            r_snap_y   <= pos_y;
            r_snap_btn <= buttons;
            r_tx       <= tx_byte(B0_IDX, pos_x, pos_y, buttons);
            r_rx       <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_ss_rise) begin
            r_frame_err <= 1'b1;
          end else if (w_sclk_rise) begin
            r_rx <= {r_rx[6:0], w_mosi_s};
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt  <= '0;
              r_byte_cnt <= r_byte_cnt + BCW'(1);
              if (r_byte_cnt == '0) r_cmd <= {r_rx[6:0], w_mosi_s};
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end else if (w_sclk_fall) begin
            // Byte boundary loads the next field; a fall before any rise is ignored.
            if (r_bit_cnt != 3'd0)
              r_tx <= {r_tx[6:0], 1'b0};
            else if (r_byte_cnt != '0)
              r_tx <= tx_byte(int'(r_byte_cnt), r_snap_x, r_snap_y, r_snap_btn);
          end
        end
        ST_HOLD: begin
          if (w_ss_rise) begin
            if (r_cmd[7:2] == CMD_PREFIX) begin
              r_led       <= r_cmd[1:0];
              r_xfer_done <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign miso      = w_miso;
  assign led       = r_led;
  assign xfer_done = r_xfer_done;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_jstk_spi_slave.sv
// Self-checking bench for jstk_spi_slave: directed and random SPI frames
// compared against expected bytes, pulses and LED state computed arithmetically.
module tb_jstk_spi_slave;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 50;   // clk cycles per sclk half period (1 MHz)
  localparam int LAT         = SYNC_STAGES + 1;

  logic       clk = 1'b0;
  logic       rst, ss, sclk, mosi, miso;
  logic [9:0] pos_x, pos_y;
  logic [2:0] buttons;
  logic [1:0] led;
  logic       xfer_done, frame_err;

  int n_total = 0, n_bad = 0;
  int n_done = 0, n_err = 0, n_both = 0;

  logic [7:0] m_bytes[6];
  logic [7:0] got[6];
  logic [1:0] exp_led = 2'b00;

  always #5 clk = ~clk;

  jstk_spi_slave #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BYTES(5)) dut (
    .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
    .pos_x(pos_x), .pos_y(pos_y), .buttons(buttons), .led(led),
    .xfer_done(xfer_done), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (xfer_done === 1'b1) n_done++;
    if (frame_err === 1'b1) n_err++;
    if (xfer_done === 1'b1 && frame_err === 1'b1) n_both++;
  end

  task automatic check_val(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_total++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  // One frame of nbits sclk periods; rst_bit/chg_bit >= 0 inject a reset
  // pulse or a pos_x change before that bit.
  task automatic run_frame(input int nbits, input int rst_bit, input int chg_bit, input string tag);
    logic [7:0] expb[6];
    logic [1:0] exp_pulse;
    int         done0, err0;
    bit         was_rst;
    expb[0] = 8'(pos_x % 256);
    expb[1] = 8'(pos_x / 256);
    expb[2] = 8'(pos_y % 256);
    expb[3] = 8'(pos_y / 256);
    expb[4] = 8'(buttons);
    expb[5] = 8'h00;
    for (int k = 0; k < 6; k++) got[k] = 8'h00;
    done0   = n_done;
    err0    = n_err;
    was_rst = (rst_bit >= 0) && (rst_bit < nbits);

    ss = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) pos_x = 10'h000;
      if (i == rst_bit) begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
      mosi = m_bytes[i / 8][7 - (i % 8)];
      repeat (HALF) @(negedge clk);
      got[i / 8][7 - (i % 8)] = miso;
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    ss = 1'b1;

    if (was_rst) begin
      exp_pulse = 2'b00;
      exp_led   = 2'b00;
    end else if (nbits < 40) begin
      exp_pulse = 2'b01;
    end else if (m_bytes[0] / 4 == 8'h20) begin
      exp_pulse = 2'b10;
      exp_led   = 2'(m_bytes[0] % 4);
    end else begin
      exp_pulse = 2'b01;
    end

    repeat (LAT) @(negedge clk);
    check_val({tag, ".pulse"}, {xfer_done, frame_err}, exp_pulse);
    repeat (10) @(negedge clk);
    check_val({tag, ".n_done"}, n_done - done0, exp_pulse[1]);
    check_val({tag, ".n_err"}, n_err - err0, exp_pulse[0]);
    check_val({tag, ".led"}, led, exp_led);
    check_val({tag, ".miso_idle"}, miso, 1'b0);
    if (!was_rst)
      for (int k = 0; k < 6 && k < nbits / 8; k++)
        check_val($sformatf("%s.b%0d", tag, k), got[k], expb[k]);
    repeat (20) @(negedge clk);
  endtask

  task automatic set_cmd(input logic [7:0] cmd);
    m_bytes[0] = cmd;
    for (int k = 1; k < 6; k++) m_bytes[k] = 8'h00;
  endtask

  initial begin
    int nb;
    rst = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
    pos_x = 10'h2A5; pos_y = 10'h1F0; buttons = 3'b101;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_val("rst.miso", miso, 1'b0);
    check_val("rst.led", led, 2'b00);
    check_val("rst.xfer_done", xfer_done, 1'b0);
    check_val("rst.frame_err", frame_err, 1'b0);
    check_val("rst.pulses", n_done + n_err, 0);

    set_cmd(8'h81);
    run_frame(40, -1, -1, "nominal");

    run_frame(40, -1, 8, "snapshot");
    pos_x = 10'h2A5;

    set_cmd(8'h82);
    run_frame(17, -1, -1, "abort");
    set_cmd(8'h83);
    run_frame(40, -1, -1, "after_abort");

    set_cmd(8'h43);
    run_frame(40, -1, -1, "bad_cmd");

    set_cmd(8'h82);
    m_bytes[5] = 8'hFF;
    run_frame(48, -1, -1, "overrun");

    set_cmd(8'h81);
    run_frame(40, 20, -1, "mid_rst");
    run_frame(40, -1, -1, "after_rst");

    for (int r = 0; r < 5; r++) begin
      pos_x   = 10'($urandom);
      pos_y   = 10'($urandom);
      buttons = 3'($urandom);
      m_bytes[0] = ($urandom_range(0, 1) == 1) ? {6'b100000, 2'($urandom)} : 8'($urandom);
      for (int k = 1; k < 6; k++) m_bytes[k] = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       nb = $urandom_range(1, 39);
        3:       nb = 48;
        default: nb = 40;
      endcase
      run_frame(nb, -1, -1, $sformatf("rnd%0d", r));
    end

    check_val("pulse_overlap", n_both, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/jstk_spi_slave.md
JSTK_SPI_SLAVE -- requirements
Module: jstk_spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on ss/sclk/mosi (minimum 2).
REQ-002 SHALL have parameter FRAME_BYTES, default 5, bytes per PmodJSTK frame.
REQ-003 SHALL provide one clock and a synchronous, active-high reset, as listed in REQ-004 and REQ-005.
REQ-004 clk  input  1  100 MHz system clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 ss  input  1  SPI slave select from master, active low, asynchronous to clk.
REQ-007 sclk  input  1  SPI serial clock, mode 0, at most 1 MHz, asynchronous to clk.
REQ-008 mosi  input  1  master-out data.
REQ-009 miso  output  1  slave-out data, MSB first.
REQ-010 pos_x  input  10  emulated joystick X position, 0..1023.
REQ-011 pos_y  input  10  emulated joystick Y position, 0..1023.
REQ-012 buttons  input  3  {btn2, btn1, btn_stick}, active high.
REQ-013 led  output  2  LED bits from the last valid command byte.
REQ-014 xfer_done  output  1  one-cycle pulse after a complete, well-formed frame.
REQ-015 frame_err  output  1  one-cycle pulse after an aborted or malformed frame.

Function
REQ-016 SHALL pass ss, sclk and mosi through SYNC_STAGES flops, then detect edges on the synchronized ss and sclk.
REQ-017 SHALL implement the FSM IDLE -> SHIFT -> HOLD -> IDLE.
REQ-018 IDLE: on a synchronized ss falling edge, SHALL snapshot pos_x, pos_y and buttons, load the TX shift register with byte 0, clear the bit and byte counters, and enter SHIFT.
REQ-019 TX byte order SHALL be: b0 = pos_x[7:0], b1 = {6'b0, pos_x[9:8]}, b2 = pos_y[7:0], b3 = {6'b0, pos_y[9:8]}, b4 = {5'b0, buttons}.
REQ-020 miso SHALL present bit 7 of b0 on the cycle after the load, without waiting for any sclk edge.
REQ-021 SHIFT: on each synchronized sclk rising edge, SHALL shift mosi into the RX register and increment the bit counter.
REQ-022 SHIFT: on each synchronized sclk falling edge, SHALL shift the TX register so miso presents the next bit.
REQ-023 After 8 rising edges the byte counter SHALL increment and the next TX byte SHALL load on the following falling edge.
REQ-024 The first received byte SHALL be stored as the command; the remaining 4 received bytes SHALL be discarded.
REQ-025 After FRAME_BYTES*8 = 40 rising edges, the FSM SHALL enter HOLD with miso = 0; further sclk edges SHALL be ignored.
REQ-026 HOLD, on ss rising edge, command[7:2] == 6'b100000: SHALL set led <= command[1:0], pulse xfer_done, and go to IDLE.
REQ-027 HOLD, on ss rising edge, wrong command prefix: SHALL pulse frame_err, leave led unchanged, and go to IDLE.
REQ-028 SHIFT, ss rising edge (abort, fewer than 40 bits): SHALL go to IDLE, pulse frame_err, leave led unchanged, and not pulse xfer_done.
REQ-029 xfer_done and frame_err SHALL assert exactly one clk after the synchronized ss rising edge, and never together.
REQ-030 In IDLE, miso SHALL be 0; changes on pos_x, pos_y or buttons during a frame SHALL NOT affect that frame.
REQ-031 An sclk edge coincident with the ss falling-edge detection SHALL be ignored.

Reset
REQ-032 On rst high at a clk edge, SHALL set: FSM = IDLE, counters = 0, TX/RX/command registers = 0, miso = 0, led = 2'b00, xfer_done = 0, frame_err = 0.
REQ-033 On reset, synchronizer flops SHALL take the idle levels ss = 1, sclk = 0, mosi = 0, so that releasing reset creates no false edge.
REQ-034 rst asserted mid-frame SHALL abort the frame silently: no pulse, led unchanged from the reset value; the remainder of that frame SHALL be ignored until the next ss falling edge.

Structure
REQ-035 Shared package jstk_pkg SHALL hold: FSM state enum, FRAME_BYTES, command prefix 6'b100000, and the byte-index constants for b0..b4.
REQ-036 Sub-module sync_edge SHALL implement the SYNC_STAGES synchronizer plus rise/fall pulse outputs, with one instance each for ss and sclk.
REQ-037 mosi SHALL use the synchronizer only; the implementation SHALL be 120-400 lines.

Verification
REQ-038 Reset: rst for 3 cycles -> miso = 0, led = 00, no pulses, FSM in IDLE.
REQ-039 Nominal frame: pos_x = 0x2A5, pos_y = 0x1F0, buttons = 3'b101, master sends 0x81 then 4x 0x00 at 66.7 kHz -> miso bytes A5, 02, F0, 01, 05; led = 01; one xfer_done pulse.
REQ-040 Snapshot: change pos_x to 0x000 after byte 0 of the scenario in REQ-039 -> byte 1 is still 0x02.
REQ-041 Abort: ss high after 17 bits -> frame_err pulse, led unchanged, and the next full frame is correct.
REQ-042 Bad command 0x43 -> frame_err pulse, led unchanged; 48 sclk edges in one frame -> last 8 edges ignored, miso = 0.
REQ-043 rst pulsed during byte 2 -> no pulse, led = 00, and the following frame is correct.
